// File: rtl/scaler_v.sv
// rtl/scaler_v.sv - vertical linear downscaler with one-line buffer
//
// Blends each pixel of an emitted output line with the co-located pixel of
// the previous input line, weighted by the fractional line distance d.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   scale_step_v  vertical step, unsigned 4.12 (PIXEL_STEP = 1.0), sampled at frame start
//   di_i/de_i     input pixel and valid
//   hs_i/vs_i     line/frame start markers, qualified by de_i
//   do_o/de_o     output pixel and valid (3 clk after the input pixel)
//   hs_o/vs_o     first pixel of output line / output frame
module scaler_v #(
  parameter int PIXEL_STEP  = 4096,
  parameter int PIXEL_WIDTH = 12,
  parameter int LINE_MAX    = 2048
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            scale_step_v,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);

  localparam int LOG2_STEP = $clog2(PIXEL_STEP);
  localparam int AW        = $clog2(LINE_MAX);
  localparam int WW        = LOG2_STEP + 1;
  localparam int SW        = PIXEL_WIDTH + LOG2_STEP + 1;
  localparam logic [23:0] LINE_MAX_C = 24'(LINE_MAX);
  localparam logic [15:0] STEP_ONE   = 16'(PIXEL_STEP);

  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;
  state_t state, state_n;

  logic frame_start, line_start, accept, in_range, new_line;
  logic [23:0] li, po, x;
  logic [23:0] li_n, po_base, x_n, diff;
  logic [15:0] step_r, step_n;
  logic emit_r, emit_n;
  logic [LOG2_STEP-1:0] d_r, d_n;

  assign frame_start = de_i && hs_i && vs_i;
  assign line_start  = de_i && hs_i && !vs_i && (state == ACTIVE);
  assign new_line    = frame_start || line_start;
  assign accept      = de_i && ((state == ACTIVE) || frame_start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_FRAME;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (frame_start) state_n = ACTIVE;
  end

  // Per-pixel view of the line/emit bookkeeping; on a line start the new
  // values are used immediately by that same pixel.
  always_comb begin
    step_n  = step_r;
    li_n    = li;
    po_base = po;
    x_n     = x;
    emit_n  = emit_r;
    d_n     = d_r;
    diff    = '0;
    if (frame_start) begin
      step_n  = (scale_step_v < STEP_ONE) ? STEP_ONE : scale_step_v;
      li_n    = '0;
      po_base = '0;
    end else if (line_start) begin
      li_n = li + 24'(PIXEL_STEP);
    end
    if (new_line) begin
      x_n    = '0;
      emit_n = (po_base <= li_n);
      diff   = li_n - po_base;
      if (emit_n) d_n = diff[LOG2_STEP-1:0];
    end
  end

  assign in_range = (x_n < LINE_MAX_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      li     <= '0;
      po     <= '0;
      x      <= '0;
      step_r <= STEP_ONE;
      emit_r <= 1'b0;
      d_r    <= '0;
    end else if (accept) begin
      li     <= li_n;
      step_r <= step_n;
      emit_r <= emit_n;
      d_r    <= d_n;
      // x saturates once past the buffer so long lines cannot wrap back in
      x      <= in_range ? x_n + 24'd1 : x_n;
      if (new_line && emit_n) po <= po_base + {8'd0, step_n};
    end
  end

  // Read-first line buffer: the registered read sees the previous line.
  logic [PIXEL_WIDTH-1:0] mem [LINE_MAX];
  logic [PIXEL_WIDTH-1:0] prev1;

  always_ff @(posedge clk) begin
    if (accept && in_range) mem[x_n[AW-1:0]] <= di_i;
    prev1 <= mem[x_n[AW-1:0]];
  end

  logic                   v1, hs1, vs1, v2, hs2, vs2;
  logic [PIXEL_WIDTH-1:0] cur1;
  logic [WW-1:0]          wc1, wp1;
  logic [SW-1:0]          pc2, pp2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      cur1 <= '0;
      wc1  <= '0;
      wp1  <= '0;
      v2   <= 1'b0;
      hs2  <= 1'b0;
      vs2  <= 1'b0;
      pc2  <= '0;
      pp2  <= '0;
      do_o <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
    end else begin
      v1   <= accept && emit_n && in_range;
      hs1  <= new_line;
      vs1  <= frame_start;
      cur1 <= di_i;
      wc1  <= WW'(PIXEL_STEP) - {1'b0, d_n};
      wp1  <= {1'b0, d_n};

      v2   <= v1;
      hs2  <= hs1;
      vs2  <= vs1;
      pc2  <= SW'(cur1) * SW'(wc1);
      pp2  <= SW'(prev1) * SW'(wp1);

      de_o <= v2;
      hs_o <= v2 && hs2;
      vs_o <= v2 && vs2;
      // weights sum to PIXEL_STEP, so the result always fits PIXEL_WIDTH
      if (v2) do_o <= PIXEL_WIDTH'((pc2 + pp2 + SW'(PIXEL_STEP / 2)) >> LOG2_STEP);
    end
  end

endmodule

// File: tb/tb_scaler_v.sv
// tb/tb_scaler_v.sv - directed self-checking bench for scaler_v
module tb_scaler_v;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] scale_step_v;
  logic [11:0] di_i;
  logic        de_i, hs_i, vs_i;
  logic [11:0] do_o;
  logic        de_o, hs_o, vs_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lv [8][4];
  int o_val[$], o_hs[$], o_vs[$], o_cyc[$];
  int e_val[$], e_hs[$], e_vs[$], i_cyc[$];

  scaler_v dut (
    .clk(clk), .rst(rst), .scale_step_v(scale_step_v),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (de_o === 1'b1) begin
      o_val.push_back(int'(do_o));
      o_hs.push_back(int'(hs_o));
      o_vs.push_back(int'(vs_o));
      o_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_q();
    o_val.delete(); o_hs.delete(); o_vs.delete(); o_cyc.delete();
    e_val.delete(); e_hs.delete(); e_vs.delete(); i_cyc.delete();
  endtask

  task automatic idle(input int n);
    de_i = 0; hs_i = 0; vs_i = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_px(input int v, input bit h, input bit vv, input bit rec);
    di_i = v[11:0]; de_i = 1; hs_i = h; vs_i = vv;
    if (rec) i_cyc.push_back(cyc);
    @(posedge clk); #1;
    de_i = 0; hs_i = 0; vs_i = 0;
  endtask

  task automatic send_line(input int l, input bit first, input bit emit, input bit gaps);
    for (int p = 0; p < 4; p++) begin
      drive_px(lv[l][p], p == 0, first && (p == 0), emit);
      if (gaps) idle((l + p) % 4);
    end
    idle(2);
  endtask

  task automatic expect_line(input int val0, input int v1, input int v2, input int v3, input bit frame);
    e_val.push_back(val0); e_val.push_back(v1); e_val.push_back(v2); e_val.push_back(v3);
    for (int p = 0; p < 4; p++) begin
      e_hs.push_back(p == 0 ? 1 : 0);
      e_vs.push_back((p == 0 && frame) ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1; scale_step_v = 16'h1000; di_i = 0; de_i = 0; hs_i = 0; vs_i = 0;
    repeat (2) begin @(posedge clk); #1; end
    tests++; if (de_o !== 1'b0) begin fails++; $display("FAIL reset de_o: got %0b want 0", de_o); end
    tests++; if (hs_o !== 1'b0) begin fails++; $display("FAIL reset hs_o: got %0b want 0", hs_o); end
    tests++; if (vs_o !== 1'b0) begin fails++; $display("FAIL reset vs_o: got %0b want 0", vs_o); end
    tests++; if (do_o !== 12'd0) begin fails++; $display("FAIL reset do_o: got %0d want 0", do_o); end
    rst = 0;
    clear_q();
    for (int p = 0; p < 4; p++) lv[0][p] = 55 + p;
    send_line(0, 0, 0, 0);
    idle(5);
    tests++; if (o_val.size() != 0) begin fails++; $display("FAIL wait_frame: got %0d outputs want 0", o_val.size()); end
  endtask

  task automatic test_unity();
    clear_q();
    scale_step_v = 16'h1000;
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 4; p++) lv[l][p] = 100 * l + 7 * p + 3;
    for (int l = 0; l < 4; l++) send_line(l, l == 0, 1, 0);
    idle(6);
    for (int l = 0; l < 4; l++) expect_line(lv[l][0], lv[l][1], lv[l][2], lv[l][3], l == 0);
    tests++;
    if (o_val.size() != e_val.size()) begin
      fails++; $display("FAIL unity count: got %0d want %0d", o_val.size(), e_val.size());
    end else for (int i = 0; i < e_val.size(); i++) begin
      tests++;
      if (o_val[i] != e_val[i] || o_hs[i] != e_hs[i] || o_vs[i] != e_vs[i] || o_cyc[i] - i_cyc[i] != 3) begin
        fails++;
        $display("FAIL unity px%0d: got val=%0d hs=%0d vs=%0d lat=%0d want val=%0d hs=%0d vs=%0d lat=3",
                 i, o_val[i], o_hs[i], o_vs[i], o_cyc[i] - i_cyc[i], e_val[i], e_hs[i], e_vs[i]);
      end
    end
  endtask

  task automatic test_downscale_2to1();
    clear_q();
    scale_step_v = 16'h2000;
    for (int l = 0; l < 6; l++)
      for (int p = 0; p < 4; p++) lv[l][p] = 10 * (l + 1);
    for (int l = 0; l < 6; l++) send_line(l, l == 0, (l % 2) == 0, 0);
    idle(6);
    expect_line(10, 10, 10, 10, 1);
    expect_line(30, 30, 30, 30, 0);
    expect_line(50, 50, 50, 50, 0);
    tests++;
    if (o_val.size() != e_val.size()) begin
      fails++; $display("FAIL 2to1 count: got %0d want %0d", o_val.size(), e_val.size());
    end else for (int i = 0; i < e_val.size(); i++) begin
      tests++;
      if (o_val[i] != e_val[i] || o_hs[i] != e_hs[i] || o_vs[i] != e_vs[i] || o_cyc[i] - i_cyc[i] != 3) begin
        fails++;
        $display("FAIL 2to1 px%0d: got val=%0d hs=%0d vs=%0d lat=%0d want val=%0d hs=%0d vs=%0d lat=3",
                 i, o_val[i], o_hs[i], o_vs[i], o_cyc[i] - i_cyc[i], e_val[i], e_hs[i], e_vs[i]);
      end
    end
  endtask

  task automatic test_downscale_1p5();
    clear_q();
    scale_step_v = 16'h1800;
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 4; p++) lv[l][p] = 400 * l;
    send_line(0, 1, 1, 0);
    send_line(1, 0, 0, 0);
    send_line(2, 0, 1, 0);
    send_line(3, 0, 1, 0);
    idle(6);
    expect_line(0, 0, 0, 0, 1);
    expect_line(600, 600, 600, 600, 0);
    expect_line(1200, 1200, 1200, 1200, 0);
    tests++;
    if (o_val.size() != e_val.size()) begin
      fails++; $display("FAIL 1p5 count: got %0d want %0d", o_val.size(), e_val.size());
    end else for (int i = 0; i < e_val.size(); i++) begin
      tests++;
      if (o_val[i] != e_val[i] || o_hs[i] != e_hs[i] || o_vs[i] != e_vs[i] || o_cyc[i] - i_cyc[i] != 3) begin
        fails++;
        $display("FAIL 1p5 px%0d: got val=%0d hs=%0d vs=%0d lat=%0d want val=%0d hs=%0d vs=%0d lat=3",
                 i, o_val[i], o_hs[i], o_vs[i], o_cyc[i] - i_cyc[i], e_val[i], e_hs[i], e_vs[i]);
      end
    end
  endtask

  task automatic test_rounding();
    clear_q();
    scale_step_v = 16'h1400;
    for (int p = 0; p < 4; p++) begin lv[0][p] = 7; lv[1][p] = 1; lv[2][p] = 0; end
    send_line(0, 1, 1, 0);
    send_line(1, 0, 0, 0);
    send_line(2, 0, 1, 0);
    idle(6);
    // full-scale frame appended to the same capture
    scale_step_v = 16'h1800;
    for (int l = 4; l < 8; l++)
      for (int p = 0; p < 4; p++) lv[l][p] = 4095;
    send_line(4, 1, 1, 0);
    send_line(5, 0, 0, 0);
    send_line(6, 0, 1, 0);
    send_line(7, 0, 1, 0);
    idle(6);
    expect_line(7, 7, 7, 7, 1);
    expect_line(1, 1, 1, 1, 0);
    expect_line(4095, 4095, 4095, 4095, 1);
    expect_line(4095, 4095, 4095, 4095, 0);
    expect_line(4095, 4095, 4095, 4095, 0);
    tests++;
    if (o_val.size() != e_val.size()) begin
      fails++; $display("FAIL round count: got %0d want %0d", o_val.size(), e_val.size());
    end else for (int i = 0; i < e_val.size(); i++) begin
      tests++;
      if (o_val[i] != e_val[i] || o_hs[i] != e_hs[i] || o_vs[i] != e_vs[i] || o_cyc[i] - i_cyc[i] != 3) begin
        fails++;
        $display("FAIL round px%0d: got val=%0d hs=%0d vs=%0d lat=%0d want val=%0d hs=%0d vs=%0d lat=3",
                 i, o_val[i], o_hs[i], o_vs[i], o_cyc[i] - i_cyc[i], e_val[i], e_hs[i], e_vs[i]);
      end
    end
  endtask

  task automatic test_clamp_gaps();
    clear_q();
    scale_step_v = 16'h0800;
    for (int l = 0; l < 3; l++)
      for (int p = 0; p < 4; p++) lv[l][p] = 1000 + 300 * l + 11 * p;
    for (int l = 0; l < 3; l++) send_line(l, l == 0, 1, 1);
    idle(6);
    for (int l = 0; l < 3; l++) expect_line(lv[l][0], lv[l][1], lv[l][2], lv[l][3], l == 0);
    tests++;
    if (o_val.size() != e_val.size()) begin
      fails++; $display("FAIL clamp count: got %0d want %0d", o_val.size(), e_val.size());
    end else for (int i = 0; i < e_val.size(); i++) begin
      tests++;
      if (o_val[i] != e_val[i] || o_hs[i] != e_hs[i] || o_vs[i] != e_vs[i] || o_cyc[i] - i_cyc[i] != 3) begin
        fails++;
        $display("FAIL clamp px%0d: got val=%0d hs=%0d vs=%0d lat=%0d want val=%0d hs=%0d vs=%0d lat=3",
                 i, o_val[i], o_hs[i], o_vs[i], o_cyc[i] - i_cyc[i], e_val[i], e_hs[i], e_vs[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    scale_step_v = 16'h1000;
    for (int l = 0; l < 6; l++)
      for (int p = 0; p < 4; p++) lv[l][p] = 2000 + 150 * l + 5 * p;
    send_line(0, 1, 1, 0);
    send_line(1, 0, 1, 0);
    drive_px(lv[2][0], 1, 0, 0);
    drive_px(lv[2][1], 0, 0, 0);
    drive_px(lv[2][2], 0, 0, 0);
    #2 rst = 1;
    #1;
    tests++; if (de_o !== 1'b0) begin fails++; $display("FAIL midrst de_o: got %0b want 0", de_o); end
    tests++; if (hs_o !== 1'b0) begin fails++; $display("FAIL midrst hs_o: got %0b want 0", hs_o); end
    tests++; if (vs_o !== 1'b0) begin fails++; $display("FAIL midrst vs_o: got %0b want 0", vs_o); end
    tests++; if (do_o !== 12'd0) begin fails++; $display("FAIL midrst do_o: got %0d want 0", do_o); end
    @(posedge clk); #1;
    rst = 0;
    clear_q();
    drive_px(lv[2][3], 0, 0, 0);
    idle(2);
    send_line(3, 0, 0, 0);
    idle(4);
    send_line(4, 1, 1, 0);
    send_line(5, 0, 1, 0);
    idle(6);
    expect_line(lv[4][0], lv[4][1], lv[4][2], lv[4][3], 1);
    expect_line(lv[5][0], lv[5][1], lv[5][2], lv[5][3], 0);
    tests++;
    if (o_val.size() != e_val.size()) begin
      fails++; $display("FAIL midrst count: got %0d want %0d", o_val.size(), e_val.size());
    end else for (int i = 0; i < e_val.size(); i++) begin
      tests++;
      if (o_val[i] != e_val[i] || o_hs[i] != e_hs[i] || o_vs[i] != e_vs[i] || o_cyc[i] - i_cyc[i] != 3) begin
        fails++;
        $display("FAIL midrst px%0d: got val=%0d hs=%0d vs=%0d lat=%0d want val=%0d hs=%0d vs=%0d lat=3",
                 i, o_val[i], o_hs[i], o_vs[i], o_cyc[i] - i_cyc[i], e_val[i], e_hs[i], e_vs[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_downscale_2to1();
    test_downscale_1p5();
    test_rounding();
    test_clamp_gaps();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
